shift_right_seq: RTL

- Multi-cycle right shifter. It is the datapath companion of the combinational left-shift-by-2 used for branch/jump address formation.
- Executes srl/sra-class operations one bit position per clock, under control of the multi-cycle controller.
- Controller pulses start with operand, shift amount and mode. Block reports busy, then a one-cycle done with the result held stable.
- Sits between register-file read data and the ALU-result writeback mux.

---
 rtl/shift_right_seq.sv | 78 +++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle srl/sra shifter, one bit position per clock; done arrives shamt+1 cycles after start.
// start is only taken in IDLE and is silently dropped while busy; result holds until the next accepted start.
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             arith_q, arith_d;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        arith_d  = arith_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d = data_in;
                    count_d  = shamt;
                    arith_d  = arith;
                    state_d  = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // Sign fill only when the request was latched as arithmetic.
                result_d = {arith_q & result_q[WIDTH-1], result_q[WIDTH-1:1]};
                count_d  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            count_q  <= '0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            arith_q  <= arith_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == SHIFT) || (state_q == DONE);
    assign done   = (state_q == DONE);

endmodule
